// File: rtl/fe_inv.sv
// Field inversion over p = 2^255-19 via Fermat: a^(p-2) by left-to-right
// square-and-multiply, driving an external multi-cycle field multiplier.
module fe_inv #(
    parameter int NB    = 255,
    parameter int QUIET = 40
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [NB-1:0] a_in,
    output logic          ready,
    output logic          done,
    output logic [NB-1:0] out,
    output logic          mul_start,
    output logic [NB-1:0] mul_a,
    output logic [NB-1:0] mul_b,
    input  logic          mul_done,
    input  logic [NB-1:0] mul_out
);

    localparam int QW = $clog2(QUIET + 1);

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MU_ISSUE,
        MU_WAIT,
        FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [NB-1:0] acc_q, acc_d;
    logic [NB-1:0] base_q, base_d;
    logic [NB-1:0] out_q, out_d;
    logic [7:0]    i_q, i_d;
    logic          done_q, done_d;
    logic [QW-1:0] quiet_q, quiet_d;

    // Exponent p-2 = 2^255-21: every bit set except bits 4 and 2.
    function automatic logic exp_bit(input logic [7:0] idx);
        return !(idx == 8'd4 || idx == 8'd2);
    endfunction

    assign ready     = (state_q == IDLE) && (quiet_q == '0);
    assign done      = done_q;
    assign out       = out_q;
    assign mul_start = (state_q == SQ_ISSUE) || (state_q == MU_ISSUE);
    // acc and base only change when a product is accepted, so operands
    // stay put for the whole multiplier operation.
    assign mul_a     = acc_q;
    assign mul_b     = ((state_q == MU_ISSUE) || (state_q == MU_WAIT)) ? base_q : acc_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        base_d  = base_q;
        out_d   = out_q;
        i_d     = i_q;
        done_d  = 1'b0;
        quiet_d = (quiet_q != '0) ? quiet_q - QW'(1) : quiet_q;

        case (state_q)
            IDLE: begin
                if (ready && start) begin
                    base_d  = a_in;
                    acc_d   = a_in;
                    i_d     = 8'd253;
                    state_d = SQ_ISSUE;
                end
            end
            SQ_ISSUE: state_d = SQ_WAIT;
            SQ_WAIT: begin
                if (mul_done) begin
                    acc_d = mul_out;
                    if (exp_bit(i_q)) begin
                        state_d = MU_ISSUE;
                    end else if (i_q == 8'd0) begin
                        state_d = FINISH;
                    end else begin
                        i_d     = i_q - 8'd1;
                        state_d = SQ_ISSUE;
                    end
                end
            end
            MU_ISSUE: state_d = MU_WAIT;
            MU_WAIT: begin
                if (mul_done) begin
                    acc_d = mul_out;
                    if (i_q == 8'd0) begin
                        state_d = FINISH;
                    end else begin
                        i_d     = i_q - 8'd1;
                        state_d = SQ_ISSUE;
                    end
                end
            end
            FINISH: begin
                out_d   = acc_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The quiet window lets a multiplier operation abandoned by reset drain.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            base_q  <= '0;
            out_q   <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
            quiet_q <= QW'(QUIET);
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            out_q   <= out_d;
            i_q     <= i_d;
            done_q  <= done_d;
            quiet_q <= quiet_d;
        end
    end

endmodule
